// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctl_w3_if.sv
// IJTAG segment signals between the gate1 controller/mux side and the data-control TDR.
// The master side drives the scan enables and mux observation; the slave is the TDR.
interface firebird7_in_gate1_tessent_tdr_data_ctl_w3_if #(
    parameter int WIDTH = 3
);
    logic             ijtag_sel;
    logic             ijtag_ce;
    logic             ijtag_se;
    logic             ijtag_ue;
    logic             ijtag_si;
    logic             ijtag_so;
    logic [WIDTH-1:0] observed_data;
    logic [WIDTH-1:0] ijtag_data_in;
    logic             ijtag_select;
    logic             capture_done;

    modport master (
        output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, observed_data,
        input  ijtag_so, ijtag_data_in, ijtag_select, capture_done
    );

    modport slave (
        input  ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, observed_data,
        output ijtag_so, ijtag_data_in, ijtag_select, capture_done
    );
endinterface

// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctl_w3.sv
// IJTAG TDR controlling one gate1 data mux: captures the mux output and select,
// shifts it on the chain, and on update drives override data/select back to the mux.
module firebird7_in_gate1_tessent_tdr_data_ctl_w3 #(
    parameter int               WIDTH        = 3,
    parameter logic [WIDTH-1:0] RESET_DATA   = '0,
    parameter logic             RESET_SELECT = 1'b0
) (
    input  logic ijtag_tck,
    input  logic ijtag_reset,
    firebird7_in_gate1_tessent_tdr_data_ctl_w3_if.slave bus
);
    logic [WIDTH:0] shift_reg;
    logic [WIDTH:0] update_reg;
    logic           capture_done_q;

    // Capture beats shift beats update when enables overlap; nothing moves while deselected.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            shift_reg      <= '0;
            update_reg     <= {RESET_SELECT, RESET_DATA};
            capture_done_q <= 1'b0;
        end else begin
            capture_done_q <= 1'b0;
            if (bus.ijtag_sel) begin
                if (bus.ijtag_ce) begin
                    shift_reg      <= {update_reg[WIDTH], bus.observed_data};
                    capture_done_q <= 1'b1;
                end else if (bus.ijtag_se) begin
                    shift_reg <= {bus.ijtag_si, shift_reg[WIDTH:1]};
                end else if (bus.ijtag_ue) begin
                    update_reg <= shift_reg;
                end
            end
        end
    end

    assign bus.ijtag_so      = shift_reg[0];
    assign bus.ijtag_select  = update_reg[WIDTH];
    assign bus.ijtag_data_in = update_reg[WIDTH-1:0];
    assign bus.capture_done  = capture_done_q;
endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_data_ctl_w3.sv
// Directed self-checking bench for the gate1 data-control TDR (WIDTH=3).
module tb_firebird7_in_gate1_tessent_tdr_data_ctl_w3;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    firebird7_in_gate1_tessent_tdr_data_ctl_w3_if #(.WIDTH(3)) bus ();

    firebird7_in_gate1_tessent_tdr_data_ctl_w3 #(
        .WIDTH(3),
        .RESET_DATA(3'b000),
        .RESET_SELECT(1'b0)
    ) dut (
        .ijtag_tck(clk),
        .ijtag_reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Set enables, then advance one rising edge and settle 1 time unit after it.
    task automatic applyStimulus(input logic sel, input logic ce, input logic se,
                                 input logic ue, input logic si);
        bus.ijtag_sel = sel;
        bus.ijtag_ce  = ce;
        bus.ijtag_se  = se;
        bus.ijtag_ue  = ue;
        bus.ijtag_si  = si;
        @(posedge clk);
        #1;
    endtask

    task automatic checkMux(input string tag, input logic [2:0] data, input logic sel);
        checkOutput({tag, "_data"}, 32'(bus.ijtag_data_in), 32'(data));
        checkOutput({tag, "_select"}, 32'(bus.ijtag_select), 32'(sel));
    endtask

    initial begin
        logic [3:0] si_bits;
        logic [3:0] so_exp;

        bus.observed_data = 3'b000;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.observed_data = 3'($urandom_range(0, 7));
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        checkMux("reset", 3'b000, 1'b0);
        checkOutput("reset_done", 32'(bus.capture_done), 32'd0);
        checkOutput("reset_so", 32'(bus.ijtag_so), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        bus.observed_data = 3'b101;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("cap_done", 32'(bus.capture_done), 32'd1);
        checkOutput("cap_so0", 32'(bus.ijtag_so), 32'd1);
        so_exp = 4'b0101;
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("shout_so%0d", i), 32'(bus.ijtag_so), 32'(so_exp[i]));
            checkOutput($sformatf("shout_done%0d", i), 32'(bus.capture_done), 32'd0);
        end
        checkMux("shout_mux", 3'b000, 1'b0);

        si_bits = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, si_bits[i]);
            checkMux($sformatf("shin%0d", i), 3'b000, 1'b0);
        end
        checkOutput("shin_so", 32'(bus.ijtag_so), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMux("update", 3'b011, 1'b1);

        si_bits = 4'b1010;
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, si_bits[i]);
        bus.observed_data = 3'b111;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("desel_ce_done", 32'(bus.capture_done), 32'd0);
        checkOutput("desel_ce_so", 32'(bus.ijtag_so), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("desel_se_so", 32'(bus.ijtag_so), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkMux("desel_ue", 3'b011, 1'b1);
        checkOutput("desel_done", 32'(bus.capture_done), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMux("desel_sr_kept", 3'b010, 1'b1);

        bus.observed_data = 3'b110;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("ovl_all_done", 32'(bus.capture_done), 32'd1);
        checkOutput("ovl_all_so", 32'(bus.ijtag_so), 32'd0);
        checkMux("ovl_all_ur", 3'b010, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("ovl_seue_so", 32'(bus.ijtag_so), 32'd1);
        checkMux("ovl_seue_ur", 3'b010, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMux("ovl_sr", 3'b111, 1'b1);

        bus.observed_data = 3'b001;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.observed_data = 3'b000;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("cont_done", 32'(bus.capture_done), 32'd1);
        checkOutput("cont_so", 32'(bus.ijtag_so), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("cont_end_done", 32'(bus.capture_done), 32'd0);

        // Reload SR with all ones so that reset clearing it is visible afterwards.
        bus.observed_data = 3'b111;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mid_so", 32'(bus.ijtag_so), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        checkOutput("mid_rst_so", 32'(bus.ijtag_so), 32'd0);
        checkMux("mid_rst", 3'b000, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMux("mid_upd", 3'b000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
